// File: rtl/deser_scheduler_pkg.sv
// Shared types for the receive-side deserializer scheduler: sample type,
// scheduler state encoding and the antenna count ceiling.
package deser_scheduler_pkg;

  localparam int unsigned MAX_ANT  = 8;
  localparam int unsigned SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } complex_product_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_LOAD,
    S_DONE,
    S_DRAIN
  } sched_state_t;

  // Counter width able to hold 0..max_val; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/deser_scheduler_arb.sv
// Round-robin arbiter: picks the first requester after the last-granted
// index and registers the grant when the enable strobe is high.
module rr_arbiter #(
  parameter int unsigned NUM_ANT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ANT-1:0]         i_req,
  input  logic [$clog2(NUM_ANT)-1:0] i_last,
  input  logic                       i_grant_en,
  output logic [NUM_ANT-1:0]         o_grant_oh,
  output logic [$clog2(NUM_ANT)-1:0] o_grant_idx
);

  localparam int unsigned AW = $clog2(NUM_ANT);

  logic [AW-1:0]      w_cand;
  logic [AW-1:0]      w_pick;
  logic               w_found;
  logic [NUM_ANT-1:0] w_pick_oh;
  logic [NUM_ANT-1:0] r_grant_oh;
  logic [AW-1:0]      r_grant_idx;

  always_comb begin
    w_cand    = '0;
    w_pick    = '0;
    w_found   = 1'b0;
    w_pick_oh = '0;
    for (int unsigned i = 1; i <= NUM_ANT; i++) begin
      w_cand = AW'((32'(i_last) + i) % NUM_ANT);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
    w_pick_oh[w_pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_oh  <= '0;
      r_grant_idx <= '0;
    end else if (i_grant_en && w_found) begin
      r_grant_oh  <= w_pick_oh;
      r_grant_idx <= w_pick;
    end
  end

  assign o_grant_oh  = r_grant_oh;
  assign o_grant_idx = r_grant_idx;

endmodule

// File: rtl/deser_scheduler.sv
// Shares one deserializer between NUM_ANT antenna streams: grants one antenna
// per OFDM symbol, strips the cyclic prefix and flags complete/aborted frames.
module deser_scheduler
  import deser_scheduler_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_ANT = 2,
  parameter int unsigned CP_LEN  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic             [NUM_ANT-1:0]   in_valid,
  output logic             [NUM_ANT-1:0]   in_ready,
  input  complex_product_t [NUM_ANT-1:0]   in_x0,
  input  complex_product_t [NUM_ANT-1:0]   in_x1,
  output logic                             deser_enable,
  output complex_product_t                 deser_x_0,
  output complex_product_t                 deser_x_1,
  output logic                             frame_valid,
  output logic             [$clog2(NUM_ANT)-1:0] frame_ant,
  output logic                             frame_err
);

  localparam int unsigned AW      = $clog2(NUM_ANT);
  localparam int unsigned CP_HALF = CP_LEN / 2;
  localparam int unsigned HALF_N  = N / 2;
  localparam int unsigned CP_W    = cnt_width(CP_HALF);
  localparam int unsigned PC_W    = cnt_width(HALF_N);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [CP_W-1:0]    r_cp_cnt;
  logic [CP_W-1:0]    w_cp_nxt;
  logic [PC_W-1:0]    r_pair_cnt;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [AW-1:0]      r_last;
  logic               w_upd_last;
  logic               w_grant_en;
  logic [NUM_ANT-1:0] w_grant_oh;
  logic [AW-1:0]      w_grant_idx;
  logic               w_gvalid;
  logic               w_fv_nxt;
  logic               w_fe_nxt;

  rr_arbiter #(.NUM_ANT(NUM_ANT)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_req      (in_valid),
    .i_last     (r_last),
    .i_grant_en (w_grant_en),
    .o_grant_oh (w_grant_oh),
    .o_grant_idx(w_grant_idx)
  );

  assign w_gvalid = in_valid[w_grant_idx];

  always_comb begin
    w_state_nxt  = r_state;
    w_cp_nxt     = r_cp_cnt;
    w_pc_nxt     = r_pair_cnt;
    w_grant_en   = 1'b0;
    w_upd_last   = 1'b0;
    w_fv_nxt     = 1'b0;
    w_fe_nxt     = 1'b0;
    in_ready     = '0;
    deser_enable = 1'b0;
    deser_x_0    = '0;
    deser_x_1    = '0;
    case (r_state)
      S_IDLE: begin
        if (|in_valid) begin
          w_grant_en  = 1'b1;
          w_state_nxt = (CP_HALF == 0) ? S_LOAD : S_SKIP;
        end
      end
      S_SKIP: begin
        in_ready = w_grant_oh;
        if (w_gvalid) begin
          w_cp_nxt = r_cp_cnt + CP_W'(1);
          if (r_cp_cnt == CP_W'(CP_HALF - 1)) w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready     = w_grant_oh;
        deser_enable = w_gvalid;
        deser_x_0    = in_x0[w_grant_idx];
        deser_x_1    = in_x1[w_grant_idx];
        if (w_gvalid) begin
          w_pc_nxt = r_pair_cnt + PC_W'(1);
          if (r_pair_cnt == PC_W'(HALF_N - 1)) begin
            w_state_nxt = S_DONE;
            w_fv_nxt    = 1'b1;
          end
        end else if (r_pair_cnt != '0) begin
          // The deserializer cannot stall, so a gap mid-payload kills the symbol.
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_upd_last  = 1'b1;
      end
      S_DRAIN: begin
        in_ready = w_grant_oh;
        if (w_gvalid) begin
          w_pc_nxt = r_pair_cnt + PC_W'(1);
          if (r_pair_cnt == PC_W'(HALF_N - 1)) begin
            w_state_nxt = S_IDLE;
            w_fe_nxt    = 1'b1;
            w_upd_last  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_IDLE) begin
      w_cp_nxt = '0;
      w_pc_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cp_cnt    <= '0;
      r_pair_cnt  <= '0;
      r_last      <= AW'(NUM_ANT - 1);
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_ant   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cp_cnt    <= w_cp_nxt;
      r_pair_cnt  <= w_pc_nxt;
      if (w_upd_last) r_last <= w_grant_idx;
      frame_valid <= w_fv_nxt;
      frame_err   <= w_fe_nxt;
      frame_ant   <= (w_fv_nxt || w_fe_nxt) ? w_grant_idx : '0;
    end
  end

endmodule
